// File: rtl/dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl
//
// Direct-mapped read cache with a whole-line refill engine, a full-cache flush
// walk and saturating hit/miss statistics. One request is handled at a time.
//
// Parameters
//   ADDR_W          word address width, split {tag, index, offset}
//   DATA_W          data word width
//   INDEX_W         line index bits (2^INDEX_W lines)
//   WORDS_PER_LINE  words per line, power of two >= 2
//   CNT_W           statistics counter width
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   lookup request handshake
//   rsp_valid/rsp_data/rsp_hit     one-cycle response pulse and its payload
//   mem_req_valid/ready/addr       line fetch request towards backing memory
//   mem_rsp_valid/mem_rsp_data     refill beats, ascending offset order
//   flush/flush_done               invalidate-all request and completion pulse
//   hit_count/miss_count           saturating statistics
// -----------------------------------------------------------------------------
module dm_cache_ctrl #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int INDEX_W        = 10,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = LINES * WORDS_PER_LINE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESPOND,
        S_FLUSH
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [OFF_W-1:0]    beat_reg, beat_next;
    logic [INDEX_W-1:0]  flush_idx_reg, flush_idx_next;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic                rsp_hit_reg, rsp_hit_next;
    logic [CNT_W-1:0]    hit_count_reg, hit_count_next;
    logic [CNT_W-1:0]    miss_count_reg, miss_count_next;
    logic [LINES-1:0]    valid_reg;

    // Tag and data storage: synchronous-read RAMs, intentionally not reset.
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [WORDS];
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   data_q;

    logic                rd_en;
    logic                data_we;
    logic                tag_we;
    logic                valid_set;
    logic                valid_clr;
    logic                hit;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_idx;
    logic [OFF_W-1:0]    addr_off;
    logic [INDEX_W-1:0]  req_idx;
    logic [INDEX_W+OFF_W-1:0] req_word;

    assign addr_tag = addr_reg[ADDR_W-1 -: TAG_W];
    assign addr_idx = addr_reg[OFF_W +: INDEX_W];
    assign addr_off = addr_reg[OFF_W-1:0];
    assign req_idx  = req_addr[OFF_W +: INDEX_W];
    assign req_word = req_addr[INDEX_W+OFF_W-1:0];

    assign hit = valid_reg[addr_idx] && (tag_q == addr_tag);

    // RAM ports. Reads are issued in IDLE on acceptance, writes only happen
    // in REFILL, so the two never collide. Writes are suppressed while rst is
    // high so an aborted refill cannot update a line's tag.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            tag_q  <= tag_mem[req_idx];
            data_q <= data_mem[req_word];
        end
        if (data_we && !rst) begin
            data_mem[{addr_idx, beat_reg}] <= mem_rsp_data;
        end
        if (tag_we && !rst) begin
            tag_mem[addr_idx] <= addr_tag;
        end
    end

    // Per-line valid flops: cleared by reset or by the flush walk, set when
    // the final refill beat of a line lands.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (valid_clr && (flush_idx_reg == INDEX_W'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end else if (valid_set && (addr_idx == INDEX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            beat_reg       <= '0;
            flush_idx_reg  <= '0;
            rsp_data_reg   <= '0;
            rsp_hit_reg    <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            beat_reg       <= beat_next;
            flush_idx_reg  <= flush_idx_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_hit_reg    <= rsp_hit_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        beat_next       = beat_reg;
        flush_idx_next  = flush_idx_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_hit_next    = rsp_hit_reg;
        hit_count_next  = hit_count_reg;
        miss_count_next = miss_count_reg;
        rd_en           = 1'b0;
        data_we         = 1'b0;
        tag_we          = 1'b0;
        valid_set       = 1'b0;
        valid_clr       = 1'b0;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        mem_req_valid   = 1'b0;
        flush_done      = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                flush_idx_next = '0;
                // Flush has priority; the request is not accepted that cycle.
                if (flush) begin
                    state_next = S_FLUSH;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_next  = req_addr;
                        rd_en      = 1'b1;
                        state_next = S_LOOKUP;
                    end
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    rsp_data_next = data_q;
                    rsp_hit_next  = 1'b1;
                    if (hit_count_reg != {CNT_W{1'b1}}) begin
                        hit_count_next = hit_count_reg + CNT_W'(1);
                    end
                    state_next = S_RESPOND;
                end else begin
                    if (miss_count_reg != {CNT_W{1'b1}}) begin
                        miss_count_next = miss_count_reg + CNT_W'(1);
                    end
                    state_next = S_MISS_REQ;
                end
            end

            S_MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_next  = '0;
                    state_next = S_REFILL;
                end
            end

            S_REFILL: begin
                if (mem_rsp_valid) begin
                    data_we   = 1'b1;
                    beat_next = beat_reg + OFF_W'(1);
                    // Forward the requested word as it streams past.
                    if (beat_reg == addr_off) begin
                        rsp_data_next = mem_rsp_data;
                    end
                    if (beat_reg == {OFF_W{1'b1}}) begin
                        tag_we       = 1'b1;
                        valid_set    = 1'b1;
                        rsp_hit_next = 1'b0;
                        state_next   = S_RESPOND;
                    end
                end
            end

            S_RESPOND: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end

            S_FLUSH: begin
                valid_clr      = 1'b1;
                flush_idx_next = flush_idx_reg + INDEX_W'(1);
                if (flush_idx_reg == {INDEX_W{1'b1}}) begin
                    flush_done = 1'b1;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line-aligned fetch address, derived from the latched request so it is
    // stable for the whole handshake; zero whenever no fetch is pending.
    assign mem_req_addr = mem_req_valid ? {addr_tag, addr_idx, {OFF_W{1'b0}}} : '0;
    assign rsp_data     = rsp_data_reg;
    assign rsp_hit      = rsp_hit_reg;
    assign hit_count    = hit_count_reg;
    assign miss_count   = miss_count_reg;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_cache_ctrl
//
// Directed bench for dm_cache_ctrl. Two instances share all inputs: one at
// default parameters, one with CNT_W=2 to exercise counter saturation. A
// transaction-level model (valid/tag arrays, hit/miss tallies, expected
// response queue) predicts each response; a per-cycle compare process checks
// every rsp_valid pulse against it. Backing memory word at address a is
// 0xC0DE0000 | a.
// -----------------------------------------------------------------------------
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [14:0] req_addr = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        flush = 1'b0;

    logic        req_ready, rsp_valid, rsp_hit, mem_req_valid, flush_done;
    logic [31:0] rsp_data;
    logic [14:0] mem_req_addr;
    logic [15:0] hit_count, miss_count;

    logic        req_ready_s, rsp_valid_s, rsp_hit_s, mem_req_valid_s, flush_done_s;
    logic [31:0] rsp_data_s;
    logic [14:0] mem_req_addr_s;
    logic [1:0]  hit_count_s, miss_count_s;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .flush(flush), .flush_done(flush_done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    dm_cache_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_addr(req_addr),
        .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s), .rsp_hit(rsp_hit_s),
        .mem_req_valid(mem_req_valid_s), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr_s),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .flush(flush), .flush_done(flush_done_s),
        .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    bit   mv [1024];
    logic [2:0] mt [1024];
    int   model_hits   = 0;
    int   model_misses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return 32'hC0DE0000 | {17'b0, a};
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
        model_hits   = 0;
        model_misses = 0;
        exp_q.delete();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !req_ready; i++) tick();
        if (!req_ready) chk("req_ready_timeout", 0, 1);
    endtask

    // Compare process: every response pulse is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_hit", rsp_hit, e.hit);
                    chk("hit_count", hit_count, 64'(model_hits));
                    chk("miss_count", miss_count, 64'(model_misses));
                    chk("sat_hit_count", hit_count_s, 64'(sat3(model_hits)));
                    chk("sat_miss_count", miss_count_s, 64'(sat3(model_misses)));
                    chk("sat_rsp_data", rsp_data_s, e.data);
                end
            end
            if (mem_req_valid) chk("mem_req_aligned", mem_req_addr[1:0], 0);
        end
    end

    task automatic do_read(input logic [14:0] a, input int req_wait, input int gap);
        logic [9:0]  idx;
        logic [2:0]  tag;
        logic [14:0] line;
        bit          hit;
        exp_t        e;
        idx  = a[11:2];
        tag  = a[14:12];
        line = {a[14:2], 2'b00};
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        hit = mv[idx] && (mt[idx] == tag);
        if (hit) model_hits++; else model_misses++;
        mv[idx] = 1'b1;
        mt[idx] = tag;
        e.data = mem_word(a);
        e.hit  = hit;
        exp_q.push_back(e);
        chk("busy_after_accept", req_ready, 0);
        if (hit) begin
            chk("hit_rsp_early", rsp_valid, 0);
            chk("hit_no_mem_req", mem_req_valid, 0);
            tick();
            chk("hit_latency2", rsp_valid, 1);
            chk("hit_no_mem_req", mem_req_valid, 0);
        end else begin
            tick();
            for (int i = 0; i < req_wait; i++) begin
                chk("mem_req_held", mem_req_valid, 1);
                chk("mem_req_addr_held", mem_req_addr, line);
                tick();
            end
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_req_addr", mem_req_addr, line);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk("mem_req_dropped", mem_req_valid, 0);
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) tick();
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(15'(line + 15'(k)));
                tick();
                mem_rsp_valid = 1'b0;
                if (k < 3) chk("no_rsp_mid_refill", rsp_valid, 0);
            end
            chk("miss_rsp", rsp_valid, 1);
        end
        tick();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
        $display("read addr=0x%04h hit=%0d data=0x%08h hits=%0d misses=%0d",
                 a, hit, rsp_data, hit_count, miss_count);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_hit"}, rsp_hit, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_hit_count"}, hit_count, 0);
        chk({tag, "_miss_count"}, miss_count, 0);
        chk({tag, "_sat_hit_count"}, hit_count_s, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_values("reset");
        $display("reset released");

        // Cold miss with three cycles of mem_req back-pressure.
        do_read(15'h1235, 3, 0);
        chk("cold_rsp_data_lit", rsp_data, 32'hC0DE1235);
        chk("cold_rsp_hit_lit", rsp_hit, 0);
        chk("cold_miss_count_lit", miss_count, 1);

        // Hit on the freshly filled line.
        do_read(15'h1236, 0, 0);
        chk("hit_rsp_data_lit", rsp_data, 32'hC0DE1236);
        chk("hit_count_lit", hit_count, 1);

        // Conflict eviction on index 0x08D, then re-miss on the old tag.
        do_read(15'h5234, 1, 1);
        do_read(15'h1234, 0, 2);
        chk("conflict_miss_count_lit", miss_count, 3);
        chk("conflict_rsp_data_lit", rsp_data, 32'hC0DE1234);
        do_read(15'h5234, 0, 0);
        chk("evict_miss_count_lit", miss_count, 4);

        // Flush together with a request: flush wins. A re-asserted flush
        // mid-walk must not extend it.
        wait_ready();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 15'h5235;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
        chk("flush_not_ready", req_ready, 0);
        cnt = 1;
        while (!flush_done && cnt < 2000) begin
            flush = (cnt == 500);
            tick();
            cnt++;
        end
        flush = 1'b0;
        chk("flush_len", cnt, 1024);
        $display("flush done after %0d cycles", cnt);
        tick();
        chk("flush_done_pulse", flush_done, 0);
        chk("ready_after_flush", req_ready, 1);
        chk("flush_keeps_hits_lit", hit_count, 1);
        chk("flush_keeps_misses_lit", miss_count, 4);
        do_read(15'h5234, 0, 0);
        chk("post_flush_miss_lit", miss_count, 5);

        // Five consecutive hits: saturating instance sticks at 3.
        do_read(15'h5235, 0, 0);
        do_read(15'h5236, 0, 0);
        do_read(15'h5237, 0, 0);
        do_read(15'h5234, 0, 0);
        do_read(15'h5235, 0, 1);
        chk("hits_lit", hit_count, 6);
        chk("sat_hit_lit", hit_count_s, 3);
        chk("sat_miss_lit", miss_count_s, 3);

        // Reset after two of four refill beats.
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 15'h2238;
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(15'(15'h2238 + 15'(k)));
            tick();
        end
        mem_rsp_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_reset_values("midrefill");
        $display("reset during refill");
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        chk("stray_no_rsp", rsp_valid, 0);
        do_read(15'h2238, 0, 0);
        do_read(15'h223B, 0, 0);
        chk("post_reset_data_lit", rsp_data, 32'hC0DE223B);
        chk("post_reset_miss_lit", miss_count, 1);
        chk("post_reset_hit_lit", hit_count, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised direct-mapped read cache with a line-refill engine. It sits between a word-addressed load requester and a slower backing memory. Unlike the fixed 4K-entry, one-word-per-entry cache, it adds configurable index depth, multi-word lines and a burst refill handshake. It also adds full-cache flush, synchronous reset and hit/miss statistics. Requests are handled one at a time: hits return in 2 cycles, misses fetch a whole line before responding.

## Interface
- ADDR_W, 15, word address width; TAG_W = ADDR_W − INDEX_W − OFF_W (must be ≥1)
- DATA_W, 32, data word width
- INDEX_W, 10, line index bits; 2^INDEX_W lines
- WORDS_PER_LINE, 4, words per line, power of 2 ≥2; OFF_W = log2(WORDS_PER_LINE)
- CNT_W, 16, statistics counter width
- clk  in  1  clock; everything acts on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  high only in IDLE with flush low
- req_addr  in  ADDR_W  word address {tag, index, offset}
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DATA_W  requested word, valid with rsp_valid
- rsp_hit  out  1  1 = served from cache, 0 = served after refill
- mem_req_valid  out  1  line fetch request, held until accepted
- mem_req_ready  in  1  memory accepts fetch
- mem_req_addr  out  ADDR_W  line-aligned address, offset bits = 0
- mem_rsp_valid  in  1  one refill beat, words in ascending offset order
- mem_rsp_data  in  DATA_W  refill word
- flush  in  1  invalidate all lines; sampled in IDLE only
- flush_done  out  1  one-cycle pulse when flush walk completes
- hit_count, miss_count  out  CNT_W  saturating statistics

## Operation
- Storage: valid[2^INDEX_W] as flops; tag and data arrays are synchronous-read RAMs (not reset).
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND, FLUSH.
- IDLE: flush high → FLUSH (flush wins over a simultaneous req_valid; req_ready is 0 that cycle). Otherwise, req_valid && req_ready → latch addr, issue RAM read, → LOOKUP.
- LOOKUP: hit = valid[idx] && tag match. On hit: rsp_data = word[offset], rsp_hit=1, hit_count+1, → RESPOND. On miss: miss_count+1, → MISS_REQ.
- MISS_REQ: mem_req_valid=1, mem_req_addr={tag,idx,0}. Stay until mem_req_ready, then → REFILL with beat counter = 0.
- REFILL: each mem_rsp_valid writes data[idx][beat] and increments beat. The beat matching the latched offset is captured into rsp_data. Gaps in mem_rsp_valid are allowed. On the final beat (WORDS_PER_LINE−1), write tag, set valid[idx], rsp_hit=0, → RESPOND.
- RESPOND: rsp_valid=1 for exactly one cycle, → IDLE.
- FLUSH: clear one valid bit per cycle, index 0 upward. After the last index, pulse flush_done and → IDLE. New flush assertions during the walk are ignored.
- Counters saturate at 2^CNT_W−1 and do not wrap. Only rst clears them; flush does not.

## Timing
- Reset values: state IDLE, all valid bits 0, req_ready 1 (from the first cycle after rst deasserts), rsp_valid 0, rsp_data 0, rsp_hit 0, mem_req_valid 0, mem_req_addr 0, flush_done 0, both counters 0.
- rst during any state (including mid-refill or mid-flush) aborts to IDLE next cycle, with all of the above reset values.
  - A partially refilled line stays invalid.
  - Refill beats arriving after reset are ignored.
- Hit latency: request accepted at edge N → rsp_valid high in cycle N+2.
- Miss latency: 2 cycles + mem_req wait + WORDS_PER_LINE beats + 1.
- req_ready is 0 from acceptance until the cycle after the rsp_valid pulse.
- mem_req_valid and mem_req_addr stay stable until the handshake completes.
- Flush duration: 2^INDEX_W cycles in FLUSH, flush_done in the last one. req_ready is 0 throughout.
- mem_rsp_valid outside REFILL is ignored.

## Test plan
- Cold miss at defaults: read 0x1235 → mem_req_addr 0x1234. Refill beats A0..A3 → rsp_data A1, rsp_hit 0, miss_count 1, mem_req_valid held 3 cycles while mem_req_ready low.
- Hit: after the line is filled, read 0x1236 → rsp_valid exactly 2 cycles after acceptance, rsp_data A2, rsp_hit 1, hit_count 1, no mem_req_valid.
- Conflict eviction: fill 0x1234, then read 0x5234 (same index, tag 5) → miss and refill. Re-read 0x1234 → miss again, miss_count 3.
- Flush: flush and req_valid together in IDLE → FLUSH taken, flush_done exactly 1024 cycles later. Next read of 0x5234 misses, and counters are unchanged by the flush.
- Reset mid-refill: rst after beat 2 of 4 → all outputs at reset values. Re-read of the same address misses, and stray beats after reset do not corrupt the line.
- Saturation with CNT_W=2: five consecutive hits → hit_count stays at 3.
